// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and parity mode constants.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter 0..CYCLES_PER_BIT-1; o_tick is combinational on the terminal count.
// i_restart realigns the count to 0 on the next edge; no backpressure.
module uart_bit_timer #(
  parameter int CYCLES_PER_BIT = 21810
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int                CNT_W    = $clog2(CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);

  if (CYCLES_PER_BIT < 2) begin : g_bad_cycles_per_bit
    $error("uart_bit_timer: CYCLES_PER_BIT must be >= 2");
  end

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_reset || i_restart) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_configurable.sv
// LSB-first UART transmitter, one word per valid/ready handshake; start bit on the line the cycle after accept.
// o_ready only in IDLE, so a producer holding i_valid is stalled for the whole frame.
module uart_tx_configurable #(
  parameter int CYCLES_PER_BIT = 21810,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  import uart_pkg::*;

  localparam int               IDX_W     = $clog2(DATA_BITS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_configurable: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
    $error("uart_tx_configurable: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_configurable: STOP_BITS must be 1 or 2");
  end

  tx_state_t            r_state, w_state_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_next;
  logic                 r_stop_idx, w_stop_idx_next;
  logic                 r_parity, w_parity_next;
  logic                 r_tx, w_tx_next;
  logic                 w_tick, w_accept, w_done;

  assign w_accept = (r_state == IDLE) && i_valid && !i_reset;

  uart_bit_timer #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_restart(w_accept),
    .o_tick   (w_tick)
  );

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_idx_next  = r_bit_idx;
    w_stop_idx_next = r_stop_idx;
    w_parity_next   = r_parity;
    w_done          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next    = START;
          w_shift_next    = i_data;
          w_bit_idx_next  = '0;
          w_stop_idx_next = 1'b0;
          w_parity_next   = (PARITY_MODE == PARITY_ODD) ? ~(^i_data) : ^i_data;
        end
      end
      START: begin
        if (w_tick) w_state_next = DATA;
      end
      DATA: begin
        if (w_tick) begin
          w_shift_next   = r_shift >> 1;
          w_bit_idx_next = r_bit_idx + IDX_W'(1);
          if (r_bit_idx == LAST_IDX) begin
            w_state_next = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (w_tick) w_state_next = STOP;
      end
      STOP: begin
        if (w_tick) begin
          if (r_stop_idx == LAST_STOP) begin
            w_state_next = IDLE;
            w_done       = 1'b1;
          end else begin
            w_stop_idx_next = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Line value is registered from the next state so it tracks the state exactly.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      PARITY:  w_tx_next = w_parity_next;
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_idx <= w_stop_idx_next;
      r_parity   <= w_parity_next;
      r_tx       <= w_tx_next;
    end
  end

  assign o_tx    = r_tx;
  assign o_ready = (r_state == IDLE) && !i_reset;
  assign o_busy  = (r_state != IDLE) && !i_reset;
  assign o_done  = w_done && !i_reset;

endmodule

// File: tb/tb_uart_tx_configurable.sv
// Directed bench for uart_tx_configurable at 4 clocks per bit: 8N1, 7E2 and 8O1 instances on a shared clock/reset.
module tb_uart_tx_configurable;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [2:0] valid, tx, ready, busy, done;
  logic [7:0] d0, d2;
  logic [6:0] d1;

  int n_checks = 0;
  int n_errors = 0;

  logic cap_tx   [1:200];
  logic cap_done [1:200];
  logic cap_rdy  [1:200];

  always #5 clk = ~clk;

  uart_tx_configurable #(.CYCLES_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_8n1 (
    .clk(clk), .i_reset(i_reset), .i_data(d0), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]));

  uart_tx_configurable #(.CYCLES_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_dut_7e2 (
    .clk(clk), .i_reset(i_reset), .i_data(d1), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]));

  uart_tx_configurable #(.CYCLES_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_dut_8o1 (
    .clk(clk), .i_reset(i_reset), .i_data(d2), .i_valid(valid[2]),
    .o_ready(ready[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int sel, input logic [8:0] w);
    case (sel)
      0:       d0 = w[7:0];
      1:       d1 = w[6:0];
      default: d2 = w[7:0];
    endcase
  endtask

  // Called one step after a rising edge; returns one step into cycle 1 after the accept edge.
  task automatic start_frame(input int sel, input logic [8:0] w, input bit hold, input string tag);
    set_word(sel, w);
    valid[sel] = 1'b1;
    chk({tag, "_ready_before"}, 32'(ready[sel]), 32'd1);
    @(posedge clk); #1;
    if (!hold) valid[sel] = 1'b0;
  endtask

  // Records cycles 1..ncyc; at cycle poke a zero word is offered for one cycle.
  task automatic capture(input int sel, input int ncyc, input int poke);
    for (int c = 1; c <= ncyc; c++) begin
      if (c == poke) begin
        set_word(sel, 9'h000);
        valid[sel] = 1'b1;
      end
      if (c == poke + 1) valid[sel] = 1'b0;
      cap_tx[c]   = tx[sel];
      cap_done[c] = done[sel];
      cap_rdy[c]  = ready[sel];
      if (c < ncyc) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int off, input logic [15:0] bits, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("%s_bit%0d_c%0d", tag, b, k), 32'(cap_tx[off + b*4 + k]), 32'(bits[b]));
      end
    end
  endtask

  task automatic check_single(input string tag, input logic [15:0] bits, input int nbits);
    int n_done;
    n_done = 0;
    check_frame(tag, 1, bits, nbits);
    for (int c = 1; c <= nbits*4 + 1; c++) if (cap_done[c]) n_done++;
    chk({tag, "_done_count"}, 32'(n_done), 32'd1);
    chk({tag, "_done_last"}, 32'(cap_done[nbits*4]), 32'd1);
    chk({tag, "_ready_last"}, 32'(cap_rdy[nbits*4]), 32'd0);
    chk({tag, "_ready_after"}, 32'(cap_rdy[nbits*4 + 1]), 32'd1);
    chk({tag, "_idle_line"}, 32'(cap_tx[nbits*4 + 1]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done, gap, n_busy, n_low;
    i_reset = 1'b1;
    valid   = 3'b000;
    d0 = 8'h00; d1 = 7'h00; d2 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx",    32'(tx),    32'b111);
    chk("rst_ready", 32'(ready), 32'b000);
    chk("rst_busy",  32'(busy),  32'b000);
    chk("rst_done",  32'(done),  32'b000);
    i_reset = 1'b0;
    #1;
    chk("rst_release_ready", 32'(ready), 32'b111);
    @(posedge clk); #1;

    start_frame(0, 9'h055, 1'b0, "8n1_55");
    chk("8n1_55_busy_c1", 32'(busy[0]), 32'd1);
    capture(0, 41, -1);
    check_single("8n1_55", 16'h02AA, 10);

    start_frame(1, 9'h041, 1'b0, "7e2_41");
    capture(1, 45, -1);
    check_single("7e2_41", 16'h0682, 11);

    start_frame(2, 9'h000, 1'b0, "8o1_00");
    capture(2, 45, -1);
    check_single("8o1_00", 16'h0600, 11);

    // Back-to-back: second word presented right after the first is accepted.
    start_frame(0, 9'h0A5, 1'b1, "b2b");
    set_word(0, 9'h03C);
    capture(0, 81, -1);
    valid[0] = 1'b0;
    check_frame("b2b_a5", 1, 16'h034A, 10);
    chk("b2b_idle_line",  32'(cap_tx[41]),  32'd1);
    chk("b2b_idle_ready", 32'(cap_rdy[41]), 32'd1);
    check_frame("b2b_3c", 42, 16'h0278, 10);
    n_done = 0;
    for (int c = 1; c <= 81; c++) if (cap_done[c]) n_done++;
    chk("b2b_done_count", 32'(n_done), 32'd2);
    chk("b2b_done_first", 32'(cap_done[40]), 32'd1);
    chk("b2b_done_second", 32'(cap_done[81]), 32'd1);
    gap = 0;
    for (int c = 37; c <= 81 && cap_tx[c]; c++) gap++;
    chk("b2b_gap", 32'(gap), 32'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_no_third", 32'(busy[0]), 32'd0);

    // Reset pulse during data bit 3 (cycles 17..20) of 0xFF.
    start_frame(0, 9'h0FF, 1'b0, "rst_ff");
    repeat (17) begin
      @(posedge clk); #1;
    end
    chk("rst_ff_busy_pre", 32'(busy[0]), 32'd1);
    i_reset = 1'b1;
    #1;
    chk("rst_ff_ready_in_rst", 32'(ready[0]), 32'd0);
    chk("rst_ff_busy_in_rst",  32'(busy[0]),  32'd0);
    chk("rst_ff_done_in_rst",  32'(done[0]),  32'd0);
    @(posedge clk); #1;
    i_reset = 1'b0;
    #1;
    chk("rst_ff_tx_after",    32'(tx[0]),    32'd1);
    chk("rst_ff_ready_after", 32'(ready[0]), 32'd1);
    chk("rst_ff_busy_after",  32'(busy[0]),  32'd0);
    n_done = 0;
    n_low  = 0;
    for (int c = 0; c < 50; c++) begin
      if (done[0]) n_done++;
      if (!tx[0]) n_low++;
      @(posedge clk); #1;
    end
    chk("rst_ff_no_done", 32'(n_done), 32'd0);
    chk("rst_ff_line_high", 32'(n_low), 32'd0);

    start_frame(0, 9'h00F, 1'b0, "post_rst_0f");
    capture(0, 41, -1);
    check_single("post_rst_0f", 16'h021E, 10);

    // Zero word offered while busy must neither disturb nor follow the frame.
    start_frame(0, 9'h081, 1'b0, "busy_81");
    capture(0, 41, 10);
    check_single("busy_81", 16'h0302, 10);
    n_busy = 0;
    for (int c = 0; c < 60; c++) begin
      if (busy[0]) n_busy++;
      @(posedge clk); #1;
    end
    chk("busy_word_dropped", 32'(n_busy), 32'd0);

    // Reset and valid together: reset wins.
    set_word(0, 9'h000);
    valid[0] = 1'b1;
    i_reset  = 1'b1;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    i_reset  = 1'b0;
    #1;
    chk("rst_vs_valid_busy", 32'(busy[0]), 32'd0);
    chk("rst_vs_valid_tx",   32'(tx[0]),   32'd1);
    @(posedge clk); #1;
    chk("rst_vs_valid_busy2", 32'(busy[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
